// File: rtl/action_selector.sv
// Move-selection stage: scans the nine cells of one game state in the action RAM
// and reports the legal (unoccupied) cell with the highest signed score.
module action_selector (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  state_base,
    input  logic [8:0]  board_x,
    input  logic [8:0]  board_o,
    output logic [7:0]  read_address,
    input  logic [15:0] ram_data,
    output logic        busy,
    output logic        done,
    output logic        move_valid,
    output logic [3:0]  move_cell,
    output logic [15:0] move_score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_base;
    logic [8:0]  r_occ;
    logic [7:0]  r_addr;
    logic [3:0]  r_cnt;
    logic        r_issue;
    logic        r_cmp_valid;
    logic [3:0]  r_cmp_idx;
    logic        r_found;
    logic [3:0]  r_best_cell;
    logic [15:0] r_best_score;
    logic        r_busy;
    logic        r_done;
    logic        r_move_valid;
    logic [3:0]  r_move_cell;
    logic [15:0] r_move_score;

    logic [15:0] w_occ16;
    logic        w_legal;
    logic        w_take;
    logic        w_found_n;
    logic [3:0]  w_cell_n;
    logic [15:0] w_score_n;

    assign read_address = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign move_valid   = r_move_valid;
    assign move_cell    = r_move_cell;
    assign move_score   = r_move_score;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the scan ends once the cell-8 data has been compared
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (r_cmp_valid && (r_cmp_idx == 4'd8)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Compare the returning score against the running best (ties keep the lower cell)
    always_comb begin
        w_occ16   = {7'd0, r_occ};
        w_legal   = r_cmp_valid && !w_occ16[r_cmp_idx];
        w_take    = 1'b0;
        if (w_legal) begin
            w_take = !r_found || ($signed(ram_data) > $signed(r_best_score));
        end else begin
            w_take = 1'b0;
        end
        w_found_n = r_found | w_take;
        w_cell_n  = w_take ? r_cmp_idx : r_best_cell;
        w_score_n = w_take ? ram_data  : r_best_score;
    end

    // Address issue, compare pipeline and registered result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_base       <= 8'h00;
            r_occ        <= 9'h000;
            r_addr       <= 8'h00;
            r_cnt        <= 4'd0;
            r_issue      <= 1'b0;
            r_cmp_valid  <= 1'b0;
            r_cmp_idx    <= 4'd0;
            r_found      <= 1'b0;
            r_best_cell  <= 4'hF;
            r_best_score <= 16'h0000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_move_valid <= 1'b0;
            r_move_cell  <= 4'hF;
            r_move_score <= 16'h0000;
        end else begin
            r_busy <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_base       <= state_base;
                        r_occ        <= board_x | board_o;
                        r_addr       <= state_base;
                        r_cnt        <= 4'd0;
                        r_issue      <= 1'b1;
                        r_cmp_valid  <= 1'b0;
                        r_found      <= 1'b0;
                        r_best_cell  <= 4'hF;
                        r_best_score <= 16'h0000;
                    end
                end
                S_FETCH: begin
                    // r_cnt names the cell whose address was on the bus last cycle
                    if (r_issue) begin
                        r_cmp_valid <= 1'b1;
                        r_cmp_idx   <= r_cnt;
                        if (r_cnt == 4'd8) begin
                            r_issue <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= r_base + {4'd0, r_cnt + 4'd1};
                        end
                    end else begin
                        r_cmp_valid <= 1'b0;
                    end
                    r_found      <= w_found_n;
                    r_best_cell  <= w_cell_n;
                    r_best_score <= w_score_n;
                    if (w_next == S_DONE) begin
                        r_done       <= 1'b1;
                        r_move_valid <= w_found_n;
                        r_move_cell  <= w_found_n ? w_cell_n  : 4'hF;
                        r_move_score <= w_found_n ? w_score_n : 16'h0000;
                    end else begin
                        r_done <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: behavioural RAM, reference model of the
// best-legal-move rule, directed cases plus randomized boards and scores.
module tb_action_selector;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  state_base;
    logic [8:0]  board_x;
    logic [8:0]  board_o;
    logic [7:0]  read_address;
    logic [15:0] ram_data;
    logic        busy;
    logic        done;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic [15:0] move_score;

    logic [15:0] mem [0:255];
    int          n_checks;
    int          n_fail;

    action_selector dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .state_base   (state_base),
        .board_x      (board_x),
        .board_o      (board_o),
        .read_address (read_address),
        .ram_data     (ram_data),
        .busy         (busy),
        .done         (done),
        .move_valid   (move_valid),
        .move_cell    (move_cell),
        .move_score   (move_score)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read action RAM: data valid one cycle after the address
    always @(posedge clock) ram_data <= mem[read_address];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: highest signed score among empty cells, lowest index on ties
    task automatic model(input logic [7:0] base, input logic [8:0] bx, input logic [8:0] bo,
                         output logic ev, output logic [3:0] ec, output logic [15:0] es);
        int scores[$];
        int cells[$];
        int mx;
        logic [7:0] a;
        for (int i = 0; i < 9; i++) begin
            if (!bx[i] && !bo[i]) begin
                a = base + 8'(i);
                scores.push_back(int'($signed(mem[a])));
                cells.push_back(i);
            end
        end
        ev = 1'b0;
        ec = 4'hF;
        es = 16'h0000;
        if (scores.size() > 0) begin
            mx = scores[0];
            foreach (scores[j]) if (scores[j] > mx) mx = scores[j];
            for (int j = 0; j < scores.size(); j++) begin
                if (scores[j] == mx && !ev) begin
                    ev = 1'b1;
                    ec = 4'(cells[j]);
                    es = 16'(mx);
                end
            end
        end
    endtask

    task automatic run_scan(input logic [7:0] base, input logic [8:0] bx, input logic [8:0] bo,
                            input bit repulse);
        logic ev;
        logic [3:0] ec;
        logic [15:0] es;
        logic [7:0] ea;
        model(base, bx, bo, ev, ec, es);
        @(negedge clock);
        state_base = base;
        board_x    = bx;
        board_o    = bo;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start      = 1'b0;
        state_base = ~base;
        board_x    = ~bx;
        board_o    = 9'h000;
        check("busy_rise", busy, 1);
        check("addr0", read_address, base);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (repulse && k == 2) start = 1'b1;
            if (repulse && k == 3) start = 1'b0;
            ea = (k <= 8) ? base + 8'(k) : base + 8'd8;
            check("addr_step", read_address, ea);
            check("busy_scan", busy, 1);
            if (k < 10) begin
                check("done_early", done, 0);
            end else begin
                check("done_e10", done, 1);
                check("move_valid", move_valid, ev);
                check("move_cell", move_cell, ec);
                check("move_score", move_score, es);
            end
        end
        @(posedge clock);
        #1;
        check("done_e11", done, 0);
        check("busy_e11", busy, 0);
        check("hold_cell", move_cell, ec);
        check("hold_score", move_score, es);
    endtask

    initial begin
        int pulses;
        logic [7:0] b;
        logic [8:0] rx;
        logic [8:0] ro;
        n_checks   = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        state_base = 8'h00;
        board_x    = 9'h000;
        board_o    = 9'h000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        @(posedge clock);
        @(posedge clock);
        #1;
        check("rst_addr", read_address, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", move_valid, 0);
        check("rst_cell", move_cell, 4'hF);
        check("rst_score", move_score, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;

        // Ascending scores: last cell wins
        for (int i = 0; i < 9; i++) mem[8'h20 + i] = 16'(i + 2);
        run_scan(8'h20, 9'h000, 9'h000, 1'b0);

        // All equal: lowest index, then lowest empty index
        for (int i = 0; i < 9; i++) mem[8'h40 + i] = 16'd5;
        run_scan(8'h40, 9'h000, 9'h000, 1'b0);
        run_scan(8'h40, 9'h001, 9'h000, 1'b0);

        // Negative scores with an occupied maximum
        for (int i = 0; i < 9; i++) mem[8'h60 + i] = 16'hFFF9;
        mem[8'h64] = 16'hFFFD;
        mem[8'h63] = 16'h7FFF;
        run_scan(8'h60, 9'h000, 9'h008, 1'b0);

        // Full board: no legal move
        run_scan(8'h60, 9'h1F5, 9'h00A, 1'b0);

        // Address wrap past 8'hFF
        for (int i = 0; i < 9; i++) mem[8'hFC + 8'(i)] = 16'(i * 3);
        mem[8'h00] = 16'd1000;
        run_scan(8'hFC, 9'h000, 9'h000, 1'b0);

        // start re-pulsed mid-scan is ignored
        run_scan(8'h20, 9'h100, 9'h000, 1'b1);

        // Reset mid-scan clears outputs at once, no done afterwards
        @(negedge clock);
        state_base = 8'h30;
        start      = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_cell", move_cell, 4'hF);
        check("arst_valid", move_valid, 0);
        check("arst_score", move_score, 16'h0000);
        check("arst_addr", read_address, 8'h00);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        check("no_done_after_abort", pulses, 0);
        run_scan(8'h20, 9'h000, 9'h000, 1'b0);

        // Randomized boards and scores
        for (int it = 0; it < 25; it++) begin
            b = 8'($urandom_range(0, 255));
            for (int i = 0; i < 9; i++) begin
                if ($urandom_range(0, 3) == 0) mem[b + 8'(i)] = 16'h0005;
                else mem[b + 8'(i)] = 16'($urandom);
            end
            rx = 9'($urandom) & 9'($urandom);
            ro = 9'($urandom) & 9'($urandom);
            if (it % 7 == 6) rx = 9'h1FF;
            run_scan(b, rx, ro, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
